// File: rtl/cic_decim_ctrl.sv
// Decimation controller for a CIC filter: paces integrator/comb enables, discards warm-up
// outputs and buffers one output sample. Define CIC_CTRL_OVR_CNT_EN to add the overrun_cnt port.
module cic_decim_ctrl #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8,
    parameter int WARMUP = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  dec_ratio,
    input  logic              in_valid,
    output logic              integ_en,
    output logic              comb_en,
    input  logic [DATA_W-1:0] comb_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
`ifdef CIC_CTRL_OVR_CNT_EN
    output logic [7:0]        overrun_cnt,
`endif
    output logic              busy
);

    // WARMUP is expected to be at least 1 (one discarded output per CIC stage)
    localparam int WC_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARMUP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_ratio;
    logic [CNT_W-1:0]  r_phase;
    logic [WC_W-1:0]   r_warmCnt;
    logic              r_capPending;
    logic              w_phaseWrap;
    logic              w_capture;
    logic              w_start;
    logic              w_warmDone;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = (r_state != S_IDLE);
        integ_en    = in_valid && busy;
        w_phaseWrap = (r_phase == (r_ratio - CNT_W'(1)));
        comb_en     = integ_en && w_phaseWrap;
        w_start     = (r_state == S_IDLE) && enable;
        // A capture seen while enable is low is abandoned along with the run
        w_capture   = r_capPending && enable;
        w_warmDone  = (r_state == S_WARMUP) && w_capture && (r_warmCnt == WARM_LAST);
        if (!enable) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_nextState = S_WARMUP;
                S_WARMUP: if (w_warmDone) w_nextState = S_RUN;
                S_RUN:    w_nextState = S_RUN;
                default:  w_nextState = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ratio      <= CNT_W'(1);
            r_phase      <= '0;
            r_warmCnt    <= '0;
            r_capPending <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
`ifdef CIC_CTRL_OVR_CNT_EN
            overrun_cnt  <= 8'd0;
`endif
        end else if (w_start) begin
            r_ratio      <= (dec_ratio == '0) ? CNT_W'(1) : dec_ratio;
            r_phase      <= '0;
            r_warmCnt    <= '0;
            r_capPending <= 1'b0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
`ifdef CIC_CTRL_OVR_CNT_EN
            overrun_cnt  <= 8'd0;
`endif
        end else if (!enable) begin
            r_capPending <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            if (integ_en) begin
                r_phase <= w_phaseWrap ? '0 : (r_phase + CNT_W'(1));
            end
            r_capPending <= comb_en;
            if (w_capture) begin
                if (r_state == S_WARMUP) begin
                    r_warmCnt <= r_warmCnt + WC_W'(1);
                end else if (!out_valid || out_ready) begin
                    out_data  <= comb_data;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
`ifdef CIC_CTRL_OVR_CNT_EN
                    if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
`endif
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cic_decim_ctrl.md
CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the comb output / output sample width (Q1.15).
REQ-002 SHALL have parameter CNT_W, default 8, the width of the decimation ratio and phase counter.
REQ-003 SHALL have parameter WARMUP, default 3, the number of comb outputs discarded after start (= CIC stage count).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  run request; level-sensitive.
REQ-007 SHALL have port dec_ratio  input  CNT_W  decimation ratio R, sampled on leaving IDLE.
REQ-008 SHALL have port in_valid  input  1  one input sample presented this cycle.
REQ-009 SHALL have port integ_en  output  1  integrator-section enable.
REQ-010 SHALL have port comb_en  output  1  comb-section enable pulse.
REQ-011 SHALL have port comb_data  input  DATA_W  comb result, valid the cycle after comb_en.
REQ-012 SHALL have port out_data  output  DATA_W  decimated output sample.
REQ-013 SHALL have port out_valid  output  1  out_data holds an unconsumed sample.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid is high.
REQ-015 SHALL have port overrun  output  1  sticky flag: an output sample was dropped.
REQ-016 SHALL have port busy  output  1  FSM is not in IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WARMUP and RUN; busy = (state != IDLE).
REQ-018 IDLE -> WARMUP SHALL occur when enable=1; this transition latches R = max(dec_ratio, 1), clears the phase and warm-up counters, and clears overrun.
REQ-019 Any state -> IDLE SHALL occur on the cycle after enable=0; the transition clears out_valid and discards any pending capture.
REQ-020 integ_en SHALL equal in_valid AND (state != IDLE), combinationally.
REQ-021 The phase counter SHALL advance on each integ_en cycle; when it equals R-1 with integ_en=1, comb_en SHALL pulse for that cycle and the counter SHALL wrap to 0.
REQ-022 With R=1, comb_en SHALL equal integ_en.
REQ-023 The block SHALL capture comb_data exactly one cycle after each comb_en pulse.
REQ-024 In WARMUP, each capture SHALL be discarded and SHALL increment the warm-up counter; the WARMUP-th capture SHALL move the FSM to RUN and is itself discarded.
REQ-025 In RUN, a capture with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle, SHALL load out_data and set out_valid=1.
REQ-026 In RUN, a capture with out_valid=1 and out_ready=0 SHALL drop the new sample, keep out_data unchanged and set overrun.
REQ-027 out_valid=1 with out_ready=1 and no capture SHALL clear out_valid on the next edge.
REQ-028 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 Latency: the first RUN sample SHALL appear at out_valid two cycles after the (WARMUP+1)-th comb_en pulse.

Reset
REQ-030 Asserting reset SHALL immediately force: state=IDLE, counters=0, out_data=0, out_valid=0, overrun=0, busy=0, comb_en=0, integ_en=0.
REQ-031 Reset asserted mid-operation SHALL abandon any pending capture; after release, the block SHALL wait for enable in IDLE.

Configuration
REQ-032 With macro CIC_CTRL_OVR_CNT_EN defined, the block SHALL add output port overrun_cnt (8 bits), counting dropped samples, saturating at 255, cleared by reset and on IDLE->WARMUP.
REQ-033 With CIC_CTRL_OVR_CNT_EN undefined, overrun_cnt SHALL be absent and only the sticky overrun flag SHALL be provided.

Verification
REQ-034 Scenario: R=4, WARMUP=3, in_valid=1 continuously, out_ready=1 -> comb_en every 4th cycle; first out_valid 2 cycles after the 4th comb_en; one sample every 4 cycles thereafter.
REQ-035 Scenario: R=1, in_valid toggling 1/0 -> comb_en mirrors integ_en; captures occur one cycle after each pulse.
REQ-036 Scenario: RUN, R=2, out_ready=0 for 6 cycles -> first sample held, overrun=1, overrun_cnt=2 (when the macro is defined); out_ready=1 -> held sample accepted.
REQ-037 Scenario: capture coincides with an out_ready=1 handshake -> new sample loaded, out_valid stays 1, overrun stays 0.
REQ-038 Scenario: enable dropped mid-RUN with out_valid=1 -> next cycle IDLE, out_valid=0; re-enable with dec_ratio=0 -> R=1, overrun cleared, WARMUP restarts.
REQ-039 Scenario: reset asserted between clock edges during WARMUP -> all outputs 0 immediately; no comb_en until enable is re-asserted after release.
